// File: rtl/pipe_ctrl_if.sv
// Decode-stage control bundle presented to the pipeline sequencer, plus the
// EX-stage redirect strobe. master = decode/EX logic, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic [4:0] id_rd_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic       id_pcsel_i;
  logic       id_immsel_i;
  logic       id_regwren_i;
  logic       id_rs1sel_i;
  logic       id_rs2sel_i;
  logic       id_memren_i;
  logic       id_memwren_i;
  logic [1:0] id_wbsel_i;
  logic [3:0] id_alusel_i;
  logic       ex_redirect_i;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
           id_pcsel_i, id_immsel_i, id_regwren_i, id_rs1sel_i, id_rs2sel_i,
           id_memren_i, id_memwren_i, id_wbsel_i, id_alusel_i, ex_redirect_i
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
           id_pcsel_i, id_immsel_i, id_regwren_i, id_rs1sel_i, id_rs2sel_i,
           id_memren_i, id_memwren_i, id_wbsel_i, id_alusel_i, ex_redirect_i
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pd5 pipeline control sequencer: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, redirect flush, EX forwarding selects and debug counters.
module pipe_ctrl #(
  parameter int DWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  pipe_ctrl_if.slave      id,
  output logic            ex_valid_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_pcsel_o,
  output logic            ex_immsel_o,
  output logic            ex_regwren_o,
  output logic            ex_rs1sel_o,
  output logic            ex_rs2sel_o,
  output logic            ex_memren_o,
  output logic            ex_memwren_o,
  output logic [1:0]      ex_wbsel_o,
  output logic [3:0]      ex_alusel_o,
  output logic            mem_valid_o,
  output logic            mem_regwren_o,
  output logic            mem_memren_o,
  output logic            mem_memwren_o,
  output logic [1:0]      mem_wbsel_o,
  output logic [4:0]      mem_rd_o,
  output logic            wb_valid_o,
  output logic            wb_regwren_o,
  output logic [1:0]      wb_wbsel_o,
  output logic [4:0]      wb_rd_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic [CNTW-1:0] stall_cnt_o,
  output logic [CNTW-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_JAL = 2'd2
  } wbsel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       pcsel;
    logic       immsel;
    logic       regwren;
    logic       rs1sel;
    logic       rs2sel;
    logic       memren;
    logic       memwren;
    logic [1:0] wbsel;
    logic [3:0] alusel;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic       regwren;
    logic       memren;
    logic       memwren;
    logic [1:0] wbsel;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       valid;
    logic       regwren;
    logic [1:0] wbsel;
    logic [4:0] rd;
  } wb_t;

  if (DWIDTH < 1 || CNTW < 1) begin : g_param_check
    $error("pipe_ctrl: DWIDTH and CNTW must be positive");
  end

  ex_t            r_ex;
  mem_t           r_mem;
  wb_t            r_wb;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;

  ex_t  w_ex_next;
  logic w_ex_writer;
  logic w_mem_writer;
  logic w_wb_writer;
  logic w_load_use;
  logic w_redirect;
  logic w_stall;
  fwd_e w_fwd_a;
  fwd_e w_fwd_b;

  // x0 is excluded in the writer test, so no rd==0 stage can ever match.
  assign w_ex_writer  = r_ex.valid  & r_ex.regwren  & (r_ex.rd  != '0);
  assign w_mem_writer = r_mem.valid & r_mem.regwren & (r_mem.rd != '0);
  assign w_wb_writer  = r_wb.valid  & r_wb.regwren  & (r_wb.rd  != '0);

  assign w_load_use = w_ex_writer & (r_ex.wbsel == WB_MEM) & id.id_valid_i &
                      ((id.id_use_rs1_i & (id.id_rs1_i == r_ex.rd)) |
                       (id.id_use_rs2_i & (id.id_rs2_i == r_ex.rd)));

  // The stalled decode instruction dies on redirect, so redirect takes precedence.
  assign w_redirect = id.ex_redirect_i & r_ex.valid;
  assign w_stall    = w_load_use & ~w_redirect;

  always_comb begin
    w_ex_next = '0;
    if (!(w_redirect || w_stall)) begin
      w_ex_next.valid   = id.id_valid_i;
      w_ex_next.rs1     = id.id_rs1_i;
      w_ex_next.rs2     = id.id_rs2_i;
      w_ex_next.rd      = id.id_rd_i;
      w_ex_next.pcsel   = id.id_pcsel_i;
      w_ex_next.immsel  = id.id_immsel_i;
      w_ex_next.regwren = id.id_regwren_i;
      w_ex_next.rs1sel  = id.id_rs1sel_i;
      w_ex_next.rs2sel  = id.id_rs2sel_i;
      w_ex_next.memren  = id.id_memren_i;
      w_ex_next.memwren = id.id_memwren_i;
      w_ex_next.wbsel   = id.id_wbsel_i;
      w_ex_next.alusel  = id.id_alusel_i;
    end
  end

  // A load result in MEM is not available yet, so only non-load MEM writers forward.
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (w_mem_writer && (r_mem.wbsel != WB_MEM) && (r_mem.rd == r_ex.rs1))
      w_fwd_a = FWD_MEM;
    else if (w_wb_writer && (r_wb.rd == r_ex.rs1))
      w_fwd_a = FWD_WB;
    if (w_mem_writer && (r_mem.wbsel != WB_MEM) && (r_mem.rd == r_ex.rs2))
      w_fwd_b = FWD_MEM;
    else if (w_wb_writer && (r_wb.rd == r_ex.rs2))
      w_fwd_b = FWD_WB;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= '{valid: r_ex.valid, regwren: r_ex.regwren, memren: r_ex.memren,
                 memwren: r_ex.memwren, wbsel: r_ex.wbsel, rd: r_ex.rd};
      r_wb  <= '{valid: r_mem.valid, regwren: r_mem.regwren,
                 wbsel: r_mem.wbsel, rd: r_mem.rd};
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      if (w_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
    end
  end

  assign ex_valid_o    = r_ex.valid;
  assign ex_rs1_o      = r_ex.rs1;
  assign ex_rs2_o      = r_ex.rs2;
  assign ex_rd_o       = r_ex.rd;
  assign ex_pcsel_o    = r_ex.pcsel;
  assign ex_immsel_o   = r_ex.immsel;
  assign ex_regwren_o  = r_ex.regwren;
  assign ex_rs1sel_o   = r_ex.rs1sel;
  assign ex_rs2sel_o   = r_ex.rs2sel;
  assign ex_memren_o   = r_ex.memren;
  assign ex_memwren_o  = r_ex.memwren;
  assign ex_wbsel_o    = r_ex.wbsel;
  assign ex_alusel_o   = r_ex.alusel;

  assign mem_valid_o   = r_mem.valid;
  assign mem_regwren_o = r_mem.regwren;
  assign mem_memren_o  = r_mem.memren;
  assign mem_memwren_o = r_mem.memwren;
  assign mem_wbsel_o   = r_mem.wbsel;
  assign mem_rd_o      = r_mem.rd;

  assign wb_valid_o    = r_wb.valid;
  assign wb_regwren_o  = r_wb.regwren;
  assign wb_wbsel_o    = r_wb.wbsel;
  assign wb_rd_o       = r_wb.rd;

  assign stall_o       = w_stall;
  assign flush_o       = w_redirect;
  assign fwd_a_o       = w_fwd_a;
  assign fwd_b_o       = w_fwd_b;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule
